// File: rtl/univ_shift_reg.sv
// ============================================================================
//  Module   : univ_shift_reg
//  Purpose  : WIDTH-bit universal shift register with per-cycle mode select
//             and an autonomous right-shift burst engine.
//  Options  : USR_PARITY_EN adds the combinational even-parity output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [2:0] C_MODE_HOLD = 3'b000;
    localparam logic [2:0] C_MODE_SHL  = 3'b001;
    localparam logic [2:0] C_MODE_SHR  = 3'b010;
    localparam logic [2:0] C_MODE_LOAD = 3'b011;
    localparam logic [2:0] C_MODE_ROTL = 3'b100;
    localparam logic [2:0] C_MODE_ROTR = 3'b101;
    localparam logic [2:0] C_MODE_CLR  = 3'b110;

    localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // done defaults low so it lasts exactly one edge, and stays low while stalled.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (burst_start && (burst_len != '0)) begin
                        state_d = S_BURST;
                        cnt_d   = (burst_len > C_WIDTH) ? C_WIDTH : burst_len;
                        busy_d  = 1'b1;
                    end else begin
                        case (mode)
                            C_MODE_SHL:  shreg_d = {shreg_q[WIDTH-2:0], ser_in_r};
                            C_MODE_SHR:  shreg_d = {ser_in_l, shreg_q[WIDTH-1:1]};
                            C_MODE_LOAD: shreg_d = par_in;
                            C_MODE_ROTL: shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
                            C_MODE_ROTR: shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
                            C_MODE_CLR:  shreg_d = '0;
                            C_MODE_HOLD: shreg_d = shreg_q;
                            default:     shreg_d = shreg_q;
                        endcase
                    end
                end
                S_BURST: begin
                    shreg_d = {ser_in_l, shreg_q[WIDTH-1:1]};
                    if (cnt_q == C_ONE) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q - C_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign q         = shreg_q;
    assign ser_out_l = shreg_q[WIDTH-1];
    assign ser_out_r = shreg_q[0];
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef USR_PARITY_EN
    assign parity = ^shreg_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=8, plus WIDTH=2 and WIDTH=32 instances.
`default_nettype none

module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [2:0] mode;
    logic       ser_in_l;
    logic       ser_in_r;
    logic       burst_start;

    logic [7:0]  par_in8;
    logic [3:0]  len8;
    logic [7:0]  q8;
    logic        sol8, sor8, busy8, done8;
`ifdef USR_PARITY_EN
    logic        par8, par2, par32;
`endif

    logic [1:0]  par_in2;
    logic [1:0]  len2;
    logic [1:0]  q2;
    logic        sol2, sor2, busy2, done2;

    logic [31:0] par_in32;
    logic [5:0]  len32;
    logic [31:0] q32;
    logic        sol32, sor32, busy32, done32;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .par_in(par_in8),
        .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .burst_start(burst_start),
        .burst_len(len8), .q(q8), .ser_out_l(sol8), .ser_out_r(sor8),
        .busy(busy8), .done(done8)
`ifdef USR_PARITY_EN
        , .parity(par8)
`endif
    );

    univ_shift_reg #(.WIDTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .par_in(par_in2),
        .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .burst_start(burst_start),
        .burst_len(len2), .q(q2), .ser_out_l(sol2), .ser_out_r(sor2),
        .busy(busy2), .done(done2)
`ifdef USR_PARITY_EN
        , .parity(par2)
`endif
    );

    univ_shift_reg #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .par_in(par_in32),
        .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .burst_start(burst_start),
        .burst_len(len32), .q(q32), .ser_out_l(sol32), .ser_out_r(sor32),
        .busy(busy32), .done(done32)
`ifdef USR_PARITY_EN
        , .parity(par32)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests++;
        if ({q8, busy8, done8} !== 10'h000) begin
            fails++;
            $display("FAIL reset_init: q=%h busy=%b done=%b, want 00/0/0", q8, busy8, done8);
        end
        reset_n = 1'b1;
        mode = 3'b011; par_in8 = 8'hFF;
        tick();
        mode = 3'b000; burst_start = 1'b1; len8 = 4'd3;
        tick();
        burst_start = 1'b0;
        tests++;
        if (q8 !== 8'hFF || busy8 !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre: q=%h busy=%b, want ff/1", q8, busy8);
        end
        #3 reset_n = 1'b0;
        #1;
        tests++;
        if ({q8, busy8, done8} !== 10'h000) begin
            fails++;
            $display("FAIL reset_async: q=%h busy=%b done=%b, want 00/0/0", q8, busy8, done8);
        end
        #2 reset_n = 1'b1;
        tick();
        tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || q8 !== 8'h00) begin
            fails++;
            $display("FAIL reset_after: q=%h busy=%b done=%b, want 00/0/0", q8, busy8, done8);
        end
    endtask

    task automatic test_modes();
        logic [2:0]  modes [7] = '{3'b011, 3'b001, 3'b010, 3'b101, 3'b100, 3'b111, 3'b110};
        logic [7:0]  exp_q [7] = '{8'hA5, 8'h4B, 8'h25, 8'h92, 8'h25, 8'h25, 8'h00};
        par_in8 = 8'hA5; ser_in_r = 1'b1; ser_in_l = 1'b0;
        for (int i = 0; i < 7; i++) begin
            mode = modes[i];
            tick();
            tests++;
            if (q8 !== exp_q[i] || sol8 !== exp_q[i][7] || sor8 !== exp_q[i][0]) begin
                fails++;
                $display("FAIL mode_%0d: q=%h sol=%b sor=%b, want %h", modes[i], q8, sol8, sor8, exp_q[i]);
            end
        end
        mode = 3'b000;
    endtask

    task automatic test_burst();
        logic [7:0] exp_q [3] = '{8'h80, 8'hC0, 8'hE0};
        ser_in_l = 1'b1; len8 = 4'd3; burst_start = 1'b1; mode = 3'b000;
        tick();
        burst_start = 1'b0;
        tests++;
        if (q8 !== 8'h00 || busy8 !== 1'b1 || done8 !== 1'b0) begin
            fails++;
            $display("FAIL burst_start: q=%h busy=%b done=%b, want 00/1/0", q8, busy8, done8);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (q8 !== exp_q[i] || busy8 !== (i < 2) || done8 !== (i == 2)) begin
                fails++;
                $display("FAIL burst_shift%0d: q=%h busy=%b done=%b, want %h/%b/%b",
                         i, q8, busy8, done8, exp_q[i], (i < 2), (i == 2));
            end
        end
        tick();
        tests++;
        if (done8 !== 1'b0 || q8 !== 8'hE0) begin
            fails++;
            $display("FAIL burst_done_clear: q=%h done=%b, want e0/0", q8, done8);
        end
    endtask

    task automatic test_stall();
        int busy_cycles = 0;
        mode = 3'b110;
        tick();
        mode = 3'b000; ser_in_l = 1'b1; len8 = 4'd3; burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        if (busy8) busy_cycles++;
        tick();
        if (busy8) busy_cycles++;
        en = 1'b0; burst_start = 1'b1; mode = 3'b011; par_in8 = 8'h55; len8 = 4'd2;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (busy8) busy_cycles++;
            tests++;
            if (q8 !== 8'h80 || busy8 !== 1'b1 || done8 !== 1'b0) begin
                fails++;
                $display("FAIL stall_%0d: q=%h busy=%b done=%b, want 80/1/0", i, q8, busy8, done8);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 10 && busy8; i++) begin
            tick();
            if (busy8) busy_cycles++;
        end
        burst_start = 1'b0; mode = 3'b000;
        tests++;
        if (q8 !== 8'hE0 || done8 !== 1'b1 || busy_cycles != 5) begin
            fails++;
            $display("FAIL stall_end: q=%h done=%b busy_cycles=%0d, want e0/1/5", q8, done8, busy_cycles);
        end
    endtask

    task automatic test_saturate();
        int shifts = 0;
        mode = 3'b110;
        tick();
        mode = 3'b000; ser_in_l = 1'b1; len8 = 4'd15; burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        for (int i = 0; i < 20 && busy8; i++) begin
            tick();
            shifts++;
        end
        tests++;
        if (shifts != 8 || q8 !== 8'hFF || done8 !== 1'b1) begin
            fails++;
            $display("FAIL saturate: shifts=%0d q=%h done=%b, want 8/ff/1", shifts, q8, done8);
        end
        len8 = 4'd0; burst_start = 1'b1; mode = 3'b011; par_in8 = 8'h3C;
        tick();
        tests++;
        if (q8 !== 8'h3C || busy8 !== 1'b0 || done8 !== 1'b0) begin
            fails++;
            $display("FAIL len0_load: q=%h busy=%b done=%b, want 3c/0/0", q8, busy8, done8);
        end
        burst_start = 1'b0; mode = 3'b000;
        tick();
        tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            fails++;
            $display("FAIL len0_after: busy=%b done=%b, want 0/0", busy8, done8);
        end
    endtask

`ifdef USR_PARITY_EN
    task automatic test_parity();
        mode = 3'b011; par_in8 = 8'h07;
        tick();
        tests++;
        if (par8 !== 1'b1) begin
            fails++;
            $display("FAIL parity_07: parity=%b, want 1", par8);
        end
        par_in8 = 8'h03;
        tick();
        tests++;
        if (par8 !== 1'b0) begin
            fails++;
            $display("FAIL parity_03: parity=%b, want 0", par8);
        end
        mode = 3'b000;
    endtask
`endif

    task automatic test_width2();
        int shifts = 0;
        mode = 3'b011; par_in2 = 2'b10;
        tick();
        mode = 3'b100;
        tick();
        tests++;
        if (q2 !== 2'b01 || sol2 !== 1'b0 || sor2 !== 1'b1) begin
            fails++;
            $display("FAIL w2_rotl: q=%b, want 01", q2);
        end
        mode = 3'b110;
        tick();
        mode = 3'b000; ser_in_l = 1'b1; len2 = 2'd3; burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        for (int i = 0; i < 10 && busy2; i++) begin
            tick();
            shifts++;
        end
        tests++;
        if (shifts != 2 || q2 !== 2'b11 || done2 !== 1'b1) begin
            fails++;
            $display("FAIL w2_burst: shifts=%0d q=%b done=%b, want 2/11/1", shifts, q2, done2);
        end
    endtask

    task automatic test_width32();
        int shifts = 0;
        mode = 3'b011; par_in32 = 32'h8000_0001;
        tick();
        mode = 3'b100;
        tick();
        tests++;
        if (q32 !== 32'h0000_0003) begin
            fails++;
            $display("FAIL w32_rotl: q=%h, want 00000003", q32);
        end
        mode = 3'b101;
        tick();
        tests++;
        if (q32 !== 32'h8000_0001 || sol32 !== 1'b1 || sor32 !== 1'b1) begin
            fails++;
            $display("FAIL w32_rotr: q=%h, want 80000001", q32);
        end
        mode = 3'b000; ser_in_l = 1'b0; len32 = 6'd40; burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        for (int i = 0; i < 60 && busy32; i++) begin
            tick();
            shifts++;
        end
        tests++;
        if (shifts != 32 || q32 !== 32'h0 || done32 !== 1'b1) begin
            fails++;
            $display("FAIL w32_burst: shifts=%0d q=%h done=%b, want 32/0/1", shifts, q32, done32);
        end
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1; mode = 3'b000;
        ser_in_l = 1'b0; ser_in_r = 1'b0; burst_start = 1'b0;
        par_in8 = '0; len8 = '0; par_in2 = '0; len2 = '0; par_in32 = '0; len32 = '0;
        #12;
        test_reset();
        test_modes();
        test_burst();
        test_stall();
        test_saturate();
`ifdef USR_PARITY_EN
        test_parity();
`endif
        test_width2();
        test_width32();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
